// File: rtl/id_ex_hazard.sv
// id_ex_hazard: ID/EX pipeline register with load-use hazard detection.
// Captures ID operands, register addresses and control for EX and the
// forwarding unit; inserts one bubble per load-use dependency and squashes
// on branch flush.
// Optional: define HAZARD_BUBBLE_COUNTER_EN to count load-use bubbles on
// contador_bolhas (otherwise the output is tied to zero).
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal flow; stall_ID follows the load-use detector
// BOLHA | a load-use bubble was just loaded; detector ignored this cycle
module id_ex_hazard #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic [REG_ADDR_W-1:0] rd_ID,
  input  logic [DATA_W-1:0]     dado1_ID,
  input  logic [DATA_W-1:0]     dado2_ID,
  input  logic [DATA_W-1:0]     imm_ID,
  input  logic [DATA_W-1:0]     pc_ID,
  input  logic                  valid_ID,
  input  logic                  RegWrite_ID,
  input  logic                  MemRead_ID,
  input  logic                  MemWrite_ID,
  input  logic                  MemtoReg_ID,
  input  logic                  ALUSrc_ID,
  input  logic [ALUOP_W-1:0]    ALUOp_ID,
  input  logic                  hold,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] entrada1EX,
  output logic [REG_ADDR_W-1:0] entrada2EX,
  output logic [REG_ADDR_W-1:0] rd_EX,
  output logic [DATA_W-1:0]     dado1_EX,
  output logic [DATA_W-1:0]     dado2_EX,
  output logic [DATA_W-1:0]     imm_EX,
  output logic [DATA_W-1:0]     pc_EX,
  output logic                  valid_EX,
  output logic                  RegWrite_EX,
  output logic                  MemRead_EX,
  output logic                  MemWrite_EX,
  output logic                  MemtoReg_EX,
  output logic                  ALUSrc_EX,
  output logic [ALUOP_W-1:0]    ALUOp_EX,
  output logic                  stall_ID,
  output logic [31:0]           contador_bolhas
);

  typedef enum logic {RUN = 1'b0, BOLHA = 1'b1} state_t;

  state_t state;
  logic   haz;
  logic   load_bubble;

  // Conservative: rs2 matches even when the ID instruction does not read it.
  assign haz = valid_EX & MemRead_EX & (rd_EX != '0) & valid_ID &
               ((rd_EX == rs1_ID) | (rd_EX == rs2_ID));

  assign stall_ID    = (state == RUN) & haz & ~flush;
  assign load_bubble = flush | stall_ID;

  // Pipeline register and FSM; hold freezes everything, bubble is all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      entrada1EX  <= '0;
      entrada2EX  <= '0;
      rd_EX       <= '0;
      dado1_EX    <= '0;
      dado2_EX    <= '0;
      imm_EX      <= '0;
      pc_EX       <= '0;
      valid_EX    <= 1'b0;
      RegWrite_EX <= 1'b0;
      MemRead_EX  <= 1'b0;
      MemWrite_EX <= 1'b0;
      MemtoReg_EX <= 1'b0;
      ALUSrc_EX   <= 1'b0;
      ALUOp_EX    <= '0;
    end else if (!hold) begin
      // flush forces stall_ID low, so a flush always lands back in RUN
      state <= stall_ID ? BOLHA : RUN;
      if (load_bubble) begin
        entrada1EX  <= '0;
        entrada2EX  <= '0;
        rd_EX       <= '0;
        dado1_EX    <= '0;
        dado2_EX    <= '0;
        imm_EX      <= '0;
        pc_EX       <= '0;
        valid_EX    <= 1'b0;
        RegWrite_EX <= 1'b0;
        MemRead_EX  <= 1'b0;
        MemWrite_EX <= 1'b0;
        MemtoReg_EX <= 1'b0;
        ALUSrc_EX   <= 1'b0;
        ALUOp_EX    <= '0;
      end else begin
        entrada1EX  <= rs1_ID;
        entrada2EX  <= rs2_ID;
        rd_EX       <= rd_ID;
        dado1_EX    <= dado1_ID;
        dado2_EX    <= dado2_ID;
        imm_EX      <= imm_ID;
        pc_EX       <= pc_ID;
        valid_EX    <= valid_ID;
        RegWrite_EX <= valid_ID & RegWrite_ID;
        MemRead_EX  <= valid_ID & MemRead_ID;
        MemWrite_EX <= valid_ID & MemWrite_ID;
        MemtoReg_EX <= valid_ID & MemtoReg_ID;
        ALUSrc_EX   <= valid_ID & ALUSrc_ID;
        ALUOp_EX    <= valid_ID ? ALUOp_ID : '0;
      end
    end
  end

`ifdef HAZARD_BUBBLE_COUNTER_EN
  logic [31:0] bub_cnt;

  // Count only load-use bubbles, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_cnt <= '0;
    end else if (!hold && stall_ID && (bub_cnt != 32'hFFFF_FFFF)) begin
      bub_cnt <= bub_cnt + 32'd1;
    end
  end

  assign contador_bolhas = bub_cnt;
`else
  assign contador_bolhas = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_hazard.sv
// Directed testbench for id_ex_hazard.
module tb_id_ex_hazard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID;
  logic [31:0] dado1_ID, dado2_ID, imm_ID, pc_ID;
  logic        valid_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID;
  logic [3:0]  ALUOp_ID;
  logic        hold, flush;
  logic [4:0]  entrada1EX, entrada2EX, rd_EX;
  logic [31:0] dado1_EX, dado2_EX, imm_EX, pc_EX;
  logic        valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX;
  logic [3:0]  ALUOp_EX;
  logic        stall_ID;
  logic [31:0] contador_bolhas;

  int passed = 0;
  int total  = 0;
  int bubs   = 0;

  id_ex_hazard dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .dado1_ID(dado1_ID), .dado2_ID(dado2_ID), .imm_ID(imm_ID), .pc_ID(pc_ID),
    .valid_ID(valid_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
    .MemWrite_ID(MemWrite_ID), .MemtoReg_ID(MemtoReg_ID), .ALUSrc_ID(ALUSrc_ID),
    .ALUOp_ID(ALUOp_ID), .hold(hold), .flush(flush),
    .entrada1EX(entrada1EX), .entrada2EX(entrada2EX), .rd_EX(rd_EX),
    .dado1_EX(dado1_EX), .dado2_EX(dado2_EX), .imm_EX(imm_EX), .pc_EX(pc_EX),
    .valid_EX(valid_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .MemtoReg_EX(MemtoReg_EX), .ALUSrc_EX(ALUSrc_EX),
    .ALUOp_EX(ALUOp_EX), .stall_ID(stall_ID), .contador_bolhas(contador_bolhas)
  );

  always #5 clk = ~clk;

  logic [152:0] ex_bus;
  assign ex_bus = {entrada1EX, entrada2EX, rd_EX, dado1_EX, dado2_EX, imm_EX, pc_EX,
                   valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX,
                   ALUSrc_EX, ALUOp_EX};

  // Expected EX contents if the currently driven ID instruction is captured.
  function automatic logic [152:0] exp_bus();
    logic [8:0] ctl;
    ctl = valid_ID ? {RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, ALUOp_ID}
                   : 9'd0;
    return {rs1_ID, rs2_ID, rd_ID, dado1_ID, dado2_ID, imm_ID, pc_ID, valid_ID, ctl};
  endfunction

  function automatic logic [31:0] cnt_exp(int n);
`ifdef HAZARD_BUBBLE_COUNTER_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic v, input logic mr, input logic [31:0] seed);
    rs1_ID = a; rs2_ID = b; rd_ID = d;
    dado1_ID = seed; dado2_ID = ~seed; imm_ID = seed ^ 32'h5A5A_A5A5; pc_ID = seed << 2;
    valid_ID = v; RegWrite_ID = 1'b1; MemRead_ID = mr; MemWrite_ID = seed[4];
    MemtoReg_ID = mr; ALUSrc_ID = seed[5]; ALUOp_ID = seed[3:0];
  endtask

  task automatic test_reset();
    drive(5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom_range(1, 31)), 1'b1, 1'b1, $urandom);
    tick();
    total++;
    if (valid_EX !== 1'b1) $display("FAIL reset_preload: valid_EX got %b want 1", valid_EX);
    else passed++;
    drive(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, $urandom);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (ex_bus !== '0) $display("FAIL reset_regs: got %h want 0", ex_bus);
    else passed++;
    total++;
    if (stall_ID !== 1'b0 || contador_bolhas !== 32'd0)
      $display("FAIL reset_stall_cnt: got stall=%b cnt=%0d want 0/0", stall_ID, contador_bolhas);
    else passed++;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    bubs = 0;
    tick();
  endtask

  task automatic test_load_use();
    drive(5'd2, 5'd3, 5'd5, 1'b1, 1'b1, 32'h1000_0011);
    tick();
    drive(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 32'h2222_0020);
    #1;
    total++;
    if (stall_ID !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall_ID);
    else passed++;
    tick();
    bubs++;
    total++;
    if (ex_bus !== '0) $display("FAIL lu_bubble: got %h want 0", ex_bus);
    else passed++;
    total++;
    if (stall_ID !== 1'b0) $display("FAIL lu_stall_drop: got %b want 0", stall_ID);
    else passed++;
    tick();
    total++;
    if (ex_bus !== exp_bus() || entrada1EX !== 5'd5)
      $display("FAIL lu_consumer: got %h want %h", ex_bus, exp_bus());
    else passed++;
    total++;
    if (contador_bolhas !== cnt_exp(bubs))
      $display("FAIL lu_count: got %0d want %0d", contador_bolhas, cnt_exp(bubs));
    else passed++;
  endtask

  task automatic test_no_hazard();
    // add x5 producer (no MemRead)
    drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'h0000_0033);
    tick();
    drive(5'd5, 5'd5, 5'd8, 1'b1, 1'b0, 32'h0000_0044);
    #1;
    total++;
    if (stall_ID !== 1'b0) $display("FAIL nh_alu_stall: got %b want 0", stall_ID);
    else passed++;
    // load into x0
    tick();
    total++;
    if (ex_bus !== exp_bus()) $display("FAIL nh_alu_pass: got %h want %h", ex_bus, exp_bus());
    else passed++;
    drive(5'd3, 5'd4, 5'd0, 1'b1, 1'b1, 32'h0000_0055);
    tick();
    drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 32'h0000_0066);
    #1;
    total++;
    if (stall_ID !== 1'b0) $display("FAIL nh_x0_stall: got %b want 0", stall_ID);
    else passed++;
    tick();
    total++;
    if (ex_bus !== exp_bus() || contador_bolhas !== cnt_exp(bubs))
      $display("FAIL nh_x0_pass: got %h cnt=%0d want %h cnt=%0d", ex_bus, contador_bolhas,
               exp_bus(), cnt_exp(bubs));
    else passed++;
  endtask

  task automatic test_flush_hazard();
    drive(5'd2, 5'd3, 5'd5, 1'b1, 1'b1, 32'h0000_0077);
    tick();
    drive(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 32'h0000_0088);
    flush = 1'b1;
    #1;
    total++;
    if (stall_ID !== 1'b0) $display("FAIL fl_stall: got %b want 0", stall_ID);
    else passed++;
    tick();
    flush = 1'b0;
    total++;
    if (ex_bus !== '0) $display("FAIL fl_bubble: got %h want 0", ex_bus);
    else passed++;
    tick();
    total++;
    if (ex_bus !== exp_bus() || contador_bolhas !== cnt_exp(bubs))
      $display("FAIL fl_next: got %h cnt=%0d want %h cnt=%0d", ex_bus, contador_bolhas,
               exp_bus(), cnt_exp(bubs));
    else passed++;
  endtask

  task automatic test_hold();
    logic [152:0] lw_bus;
    drive(5'd2, 5'd3, 5'd5, 1'b1, 1'b1, 32'h0000_0099);
    tick();
    lw_bus = exp_bus();
    drive(5'd6, 5'd5, 5'd9, 1'b1, 1'b0, 32'h0000_00AA);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (stall_ID !== 1'b1 || ex_bus !== lw_bus || contador_bolhas !== cnt_exp(bubs))
        $display("FAIL hold_frozen%0d: got stall=%b %h cnt=%0d want 1 %h cnt=%0d", i,
                 stall_ID, ex_bus, contador_bolhas, lw_bus, cnt_exp(bubs));
      else passed++;
    end
    hold = 1'b0;
    tick();
    bubs++;
    total++;
    if (ex_bus !== '0 || stall_ID !== 1'b0)
      $display("FAIL hold_bubble: got %h stall=%b want 0 0", ex_bus, stall_ID);
    else passed++;
    tick();
    total++;
    if (ex_bus !== exp_bus() || contador_bolhas !== cnt_exp(bubs))
      $display("FAIL hold_consumer: got %h cnt=%0d want %h cnt=%0d", ex_bus, contador_bolhas,
               exp_bus(), cnt_exp(bubs));
    else passed++;
  endtask

  task automatic test_reset_mid_stall();
    drive(5'd2, 5'd3, 5'd5, 1'b1, 1'b1, 32'h0000_00BB);
    tick();
    drive(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 32'h0000_00CC);
    #2 rst_n = 1'b0;
    #1;
    bubs = 0;
    total++;
    if (valid_EX !== 1'b0 || stall_ID !== 1'b0 || contador_bolhas !== 32'd0)
      $display("FAIL rst_mid: got valid=%b stall=%b cnt=%0d want 0 0 0", valid_EX, stall_ID,
               contador_bolhas);
    else passed++;
    rst_n = 1'b1;
    tick();
    total++;
    if (ex_bus !== exp_bus()) $display("FAIL rst_mid_next: got %h want %h", ex_bus, exp_bus());
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] seeds [4] = '{32'h1111_1117, 32'h2222_2222, 32'h3333_3339, 32'h4444_444E};
    logic        vals  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(5'd1, 5'd2, 5'd7, vals[i], seeds[i][0], seeds[i]);
      #1;
      total++;
      if (stall_ID !== 1'b0) $display("FAIL b2b_stall%0d: got %b want 0", i, stall_ID);
      else passed++;
      tick();
      total++;
      if (ex_bus !== exp_bus())
        $display("FAIL b2b_pass%0d: got %h want %h", i, ex_bus, exp_bus());
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush_hazard();
    test_hold();
    test_reset_mid_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
